// File: rtl/interrupt_fsm.sv
// interrupt_fsm: emits one PULSE_CYCLES-wide interrupt per press and re-arms only after press is seen low.
// Define INTFSM_SYNC_EN to pass press through a 2-flop synchronizer whose flops reset to 1.
module interrupt_fsm #(
    parameter int PULSE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic press,
    output logic interrupt
);
    localparam int CW = $clog2(PULSE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT_RELEASE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic p;
`ifdef INTFSM_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk) begin
        sync <= reset ? 2'b11 : {sync[0], press};
    end
    assign p = sync[1];
`else
    assign p = press;
`endif
    // interrupt gets its own flop so the CPU sees a clean registered level
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_RELEASE;
            cnt       <= '0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            interrupt <= state_n == PULSE;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (p) begin
                    state_n = PULSE;
                    cnt_n   = CW'(PULSE_CYCLES - 1);
                end
            end
            PULSE: begin
                if (cnt != '0) cnt_n = cnt - CW'(1);
                else state_n = p ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!p) state_n = IDLE;
            end
            default: state_n = WAIT_RELEASE;
        endcase
    end
endmodule

// File: tb/tb_interrupt_fsm.sv
// tb_interrupt_fsm: drives a PULSE_CYCLES=1 and a PULSE_CYCLES=3 instance from the same press/reset
// and scores each interrupt against per-cycle expectations queued at drive time.
module tb_interrupt_fsm;
`ifdef INTFSM_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic press = 1'b0;
    logic int1, int3;
    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    logic q1[$];
    logic q3[$];

    always #5 clk = ~clk;

    interrupt_fsm #(.PULSE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .press(press), .interrupt(int1));
    interrupt_fsm #(.PULSE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .press(press), .interrupt(int3));

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: interrupt=%b expected %b", tag, cyc_n, obs, exp);
        end
    endtask

    // e1/e3: interrupt expected right after this edge when press feeds the FSM directly;
    // the synchronized build shows the same values D cycles later.
    task automatic cyc(input logic p, input logic r, input logic e1, input logic e3);
        press = p;
        reset = r;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (r) begin
            check("reset_p1", int1, 1'b0);
            check("reset_p3", int3, 1'b0);
            q1 = {};
            q3 = {};
            repeat (D) begin
                q1.push_back(1'b0);
                q3.push_back(1'b0);
            end
        end else begin
            q1.push_back(e1);
            q3.push_back(e3);
            if (q1.size() > D) check("pulse_p1", int1, q1.pop_front());
            if (q3.size() > D) check("pulse_p3", int3, q3.pop_front());
        end
    endtask

    task automatic seq(input string p, input string e1, input string e3);
        for (int i = 0; i < p.len(); i++)
            cyc(p[i] == "1", 1'b0, e1[i] == "1", e3[i] == "1");
    endtask

    initial begin
        // reset then idle
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        seq("00000", "00000", "00000");
        // single-cycle press
        seq("10000000000", "10000000000", "11100000000");
        // long hold: one pulse only
        seq("11111111110000000000", "10000000000000000000", "11100000000000000000");
        // 1,0,1,0: two pulses at P=1, merged at P=3
        seq("10100000", "10100000", "11100000");
        // one low cycle after the pulse re-arms
        seq("11101110000", "10001000000", "11101110000");
        // reset mid-pulse with press held through release
        seq("11", "10", "11");
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        seq("11111", "00000", "00000");
        seq("0100000", "0100000", "0111000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
